// File: rtl/slowadc_pkg.sv
// Shared constants for the slow-ADC monitor: widths, local-bus offsets, readback map.
package slowadc_pkg;

  localparam int NCHAN = 8;
  localparam int CHW   = $clog2(NCHAN);
  localparam int DW    = 12;
  localparam int SHIFT = 4;
  localparam int AW    = DW + SHIFT;
  localparam int CW    = 4;

  localparam logic [CW-1:0] CNT_MAX = 4'd15;

  localparam logic [6:0] LB_THR       = 7'h40;
  localparam logic [6:0] LB_DEB       = 7'h48;
  localparam logic [6:0] LB_CLR       = 7'h49;
  localparam logic [6:0] LB_PRIME_CLR = 7'h4A;
  localparam logic [6:0] LB_SNAP      = 7'h4B;

  localparam logic [4:0] RD_AVG   = 5'd0;
  localparam logic [4:0] RD_CNT   = 5'd8;
  localparam logic [4:0] RD_ALARM = 5'd16;
  localparam logic [4:0] RD_MIN   = 5'd17;
  localparam logic [4:0] RD_MAX   = 5'd25;

endpackage

// File: rtl/slowadc_iir_lane.sv
// Combinational S2 update for one sample: IIR accumulator, window check, debounce
// counter and alarm-set decision. Time-shared across all channels.
module slowadc_iir_lane
  import slowadc_pkg::*;
(
  input  logic          primed,
  input  logic [AW-1:0] acc_in,
  input  logic [CW-1:0] cnt_in,
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] thr_lo,
  input  logic [DW-1:0] thr_hi,
  input  logic [CW-1:0] deb_n,
  output logic [AW-1:0] acc_out,
  output logic [CW-1:0] cnt_out,
  output logic          out,
  output logic          alarm_set
);

  logic [CW-1:0] deb_eff;

  always_comb begin
    deb_eff = (deb_n == '0) ? CW'(1) : deb_n;
    out     = (data > thr_hi) || (data < thr_lo);

    // acc stays below 4095<<SHIFT, so the 16-bit update cannot wrap
    if (!primed) acc_out = AW'(data) << SHIFT;
    else         acc_out = acc_in - (acc_in >> SHIFT) + AW'(data);

    if (!out)                  cnt_out = '0;
    else if (cnt_in == CNT_MAX) cnt_out = cnt_in;
    else                       cnt_out = cnt_in + 1'b1;

    // >= so a still-out channel re-asserts the alarm after a host clear
    alarm_set = out && (cnt_out >= deb_eff);
  end

endmodule

// File: rtl/slowadc_monitor.sv
// Slow-ADC scan monitor: per-channel IIR average, window/debounce sticky alarms, readback.
// Optional SLOWADC_MINMAX_EN adds per-channel raw min/max tracking and the 0x4B snapshot.
module slowadc_monitor
  import slowadc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lb_data,
  input  logic [6:0]  lb_addr,
  input  logic        lb_write,
  input  logic        sample_valid,
  input  logic [2:0]  sample_chan,
  input  logic [11:0] sample_data,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [7:0]  alarm,
  output logic        alarm_any
);

  logic             s0_valid, s1_valid;
  logic [CHW-1:0]   s0_chan, s1_chan;
  logic [DW-1:0]    s0_data, s1_data;
  logic [AW-1:0]    s1_acc;
  logic [CW-1:0]    s1_cnt;
  logic             s1_primed;

  // dpram-style per-channel state, written from S2 and read into S1
  logic [AW-1:0]    acc_mem [NCHAN];
  logic [CW-1:0]    cnt_mem [NCHAN];
  logic [NCHAN-1:0] primed;
  logic [DW-1:0]    thr_lo  [NCHAN];
  logic [DW-1:0]    thr_hi  [NCHAN];
  logic [CW-1:0]    deb_n;

  logic [AW-1:0]    lane_acc;
  logic [CW-1:0]    lane_cnt;
  logic             lane_out, lane_set;
  logic             thr_wr, deb_wr, clr_wr, prime_clr, fwd;
  logic [NCHAN-1:0] set_mask, clr_mask;
  logic [15:0]      rd_next;
  logic [7:0]       snap;
  logic             unused_bits;

`ifdef SLOWADC_MINMAX_EN
  logic [DW-1:0]    min_mem [NCHAN];
  logic [DW-1:0]    max_mem [NCHAN];
`endif

  assign unused_bits = ^{lb_data[31:28], lb_data[15:12], lane_out};

  assign thr_wr    = lb_write && (lb_addr[6:3] == LB_THR[6:3]);
  assign deb_wr    = lb_write && (lb_addr == LB_DEB);
  assign clr_wr    = lb_write && (lb_addr == LB_CLR);
  assign prime_clr = lb_write && (lb_addr == LB_PRIME_CLR) && lb_data[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_chan  <= '0;
      s0_data  <= '0;
    end else begin
      s0_valid <= sample_valid;
      if (sample_valid) begin
        s0_chan <= sample_chan;
        s0_data <= sample_data;
      end
    end
  end

  // S1 takes the S2 result directly when S2 is writing the same channel this edge
  assign fwd = s1_valid && (s1_chan == s0_chan);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_chan   <= '0;
      s1_data   <= '0;
      s1_acc    <= '0;
      s1_cnt    <= '0;
      s1_primed <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_chan   <= s0_chan;
        s1_data   <= s0_data;
        s1_acc    <= fwd ? lane_acc : acc_mem[s0_chan];
        s1_cnt    <= prime_clr ? '0 : (fwd ? lane_cnt : cnt_mem[s0_chan]);
        s1_primed <= !prime_clr && (fwd || primed[s0_chan]);
      end
    end
  end

  slowadc_iir_lane u_lane (
    .primed    (s1_primed),
    .acc_in    (s1_acc),
    .cnt_in    (s1_cnt),
    .data      (s1_data),
    .thr_lo    (thr_lo[s1_chan]),
    .thr_hi    (thr_hi[s1_chan]),
    .deb_n     (deb_n),
    .acc_out   (lane_acc),
    .cnt_out   (lane_cnt),
    .out       (lane_out),
    .alarm_set (lane_set)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHAN; i++) acc_mem[i] <= '0;
    end else if (s1_valid) begin
      acc_mem[s1_chan] <= lane_acc;
    end
  end

  // The prime/counter clear overrides a same-edge write-back; acc is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHAN; i++) cnt_mem[i] <= '0;
      primed <= '0;
    end else if (prime_clr) begin
      for (int i = 0; i < NCHAN; i++) cnt_mem[i] <= '0;
      primed <= '0;
    end else if (s1_valid) begin
      cnt_mem[s1_chan] <= lane_cnt;
      primed[s1_chan]  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHAN; i++) begin
        thr_lo[i] <= '0;
        thr_hi[i] <= '1;
      end
      deb_n <= CW'(1);
    end else begin
      if (thr_wr) begin
        thr_lo[lb_addr[CHW-1:0]] <= lb_data[11:0];
        thr_hi[lb_addr[CHW-1:0]] <= lb_data[27:16];
      end
      if (deb_wr) deb_n <= lb_data[3:0];
    end
  end

  assign set_mask = (s1_valid && lane_set) ? (NCHAN'(1) << s1_chan) : '0;
  assign clr_mask = clr_wr ? lb_data[NCHAN-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm     <= '0;
      alarm_any <= 1'b0;
    end else begin
      alarm     <= (alarm & ~clr_mask) | set_mask;
      alarm_any <= |alarm;
    end
  end

`ifdef SLOWADC_MINMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHAN; i++) begin
        min_mem[i] <= '0;
        max_mem[i] <= '0;
      end
      snap <= '0;
    end else begin
      if (s1_valid) begin
        if (!s1_primed || (s1_data < min_mem[s1_chan])) min_mem[s1_chan] <= s1_data;
        if (!s1_primed || (s1_data > max_mem[s1_chan])) max_mem[s1_chan] <= s1_data;
      end
      if (lb_write && (lb_addr == LB_SNAP)) snap <= max_mem[NCHAN-1][DW-1:DW-8];
    end
  end
`else
  assign snap = '0;
`endif

  always_comb begin
    rd_next = '0;
    if (rd_addr < RD_CNT)        rd_next = 16'(acc_mem[rd_addr[CHW-1:0]] >> SHIFT);
    else if (rd_addr < RD_ALARM) rd_next = 16'(cnt_mem[rd_addr[CHW-1:0]]);
    else if (rd_addr == RD_ALARM) rd_next = {snap, alarm};
`ifdef SLOWADC_MINMAX_EN
    else if (rd_addr < RD_MAX)   rd_next = 16'(min_mem[CHW'(rd_addr - RD_MIN)]);
    else                         rd_next = 16'(max_mem[CHW'(rd_addr - RD_MAX)]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_next;
  end

endmodule
